// File: rtl/alu_pkg.sv
// Shared opcode, funct3 and FSM encodings for the sequential ALU.
// Imported by alu_core and alu_seq.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_SLTU = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SR   = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational base-ISA ALU: result, equality and less-than.
// Registered by alu_seq.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_opsel,
  input  logic            i_sub,
  input  logic            i_unsigned,
  input  logic            i_arith,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic [XLEN-1:0] o_result,
  output logic            o_eq,
  output logic            o_slt
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_sra;
  logic [XLEN-1:0]    w_srl;
  logic               w_slt;

  assign w_shamt = i_op2[SHAMT_W-1:0];
  assign w_sra   = $signed(i_op1) >>> w_shamt;
  assign w_srl   = i_op1 >> w_shamt;
  assign w_slt   = i_unsigned ? (i_op1 < i_op2)
                              : ($signed(i_op1) < $signed(i_op2));
  assign o_eq    = (i_op1 == i_op2);
  assign o_slt   = w_slt;

  // opcode decode; the eight encodings are mutually exclusive
  always_comb begin
    o_result = '0;
    unique case (1'b1)
      (i_opsel == OP_ADD):
        o_result = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
      (i_opsel == OP_SLL):
        o_result = i_op1 << w_shamt;
      (i_opsel[2:1] == 2'b01):
        o_result = {{(XLEN-1){1'b0}}, w_slt};
      (i_opsel == OP_XOR):
        o_result = i_op1 ^ i_op2;
      (i_opsel == OP_SR):
        o_result = i_arith ? w_sra : w_srl;
      (i_opsel == OP_OR):
        o_result = i_op1 | i_op2;
      (i_opsel == OP_AND):
        o_result = i_op1 & i_op2;
      default:
        o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: 1-cycle base ops, iterative RV32M mul/div.
// Mul and div share one XLEN+1-bit adder.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic            i_mext,
  input  logic [2:0]      i_opsel,
  input  logic            i_sub,
  input  logic            i_unsigned,
  input  logic            i_arith,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_eq,
  output logic            o_slt,
  output logic            o_busy
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_e              r_state;
  logic [SHAMT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_mcand;
  logic                r_neg;
  logic                r_neg_rem;
  logic                r_hi;
  logic                r_rem;
  logic                r_eq_p;
  logic                r_slt_p;
  logic                r_valid;
  logic [XLEN-1:0]     r_result;
  logic                r_eq;
  logic                r_slt;

  logic [XLEN-1:0]     w_core_res;
  logic                w_core_eq;
  logic                w_core_slt;

  alu_core #(.XLEN(XLEN)) u_core (
    .i_opsel    (i_opsel),
    .i_sub      (i_sub),
    .i_unsigned (i_unsigned),
    .i_arith    (i_arith),
    .i_op1      (i_op1),
    .i_op2      (i_op2),
    .o_result   (w_core_res),
    .o_eq       (w_core_eq),
    .o_slt      (w_core_slt)
  );

  logic w_idle, w_mul, w_last, w_acc;
  logic w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic w_div0, w_ovf, w_spec, w_iter;
  logic [XLEN-1:0] w_mag1, w_mag2, w_spec_res;

  assign w_idle  = (r_state == S_IDLE);
  assign w_mul   = (r_state == S_MUL);
  assign w_last  = (r_cnt == SHAMT_W'(XLEN-1));
  assign o_ready = w_idle && (!r_valid || i_ready) && !i_flush;
  assign w_acc   = i_valid && o_ready;

  assign w_sgn1 = i_mext && (i_opsel == F3_MULH || i_opsel == F3_MULHSU ||
                             i_opsel == F3_DIV  || i_opsel == F3_REM);
  assign w_sgn2 = i_mext && (i_opsel == F3_MULH || i_opsel == F3_DIV ||
                             i_opsel == F3_REM);
  assign w_neg1 = w_sgn1 && i_op1[XLEN-1];
  assign w_neg2 = w_sgn2 && i_op2[XLEN-1];
  assign w_mag1 = w_neg1 ? ('0 - i_op1) : i_op1;
  assign w_mag2 = w_neg2 ? ('0 - i_op2) : i_op2;

  // DIV and REM both have funct3 bit 0 clear
  assign w_div0 = (i_op2 == '0);
  assign w_ovf  = !i_opsel[0] && (i_op1 == MINV) && (i_op2 == '1);
  assign w_spec = i_mext && i_opsel[2] && (w_div0 || w_ovf);
  assign w_iter = i_mext && !w_spec;

  // one-cycle answers for divide-by-zero and signed overflow
  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = i_opsel[1] ? i_op1 : '1;
    else
      w_spec_res = i_opsel[1] ? '0 : i_op1;
  end

  logic [XLEN-1:0]   w_hi;
  logic [XLEN:0]     w_add_a, w_add_b, w_sum;
  logic              w_cin;
  logic [2*XLEN-1:0] w_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_quo, w_remv, w_fin;

  assign w_hi    = r_acc[2*XLEN-1:XLEN];
  assign w_cin   = !w_mul;
  assign w_add_a = w_mul ? {1'b0, w_hi} : r_acc[2*XLEN-1:XLEN-1];
  assign w_add_b = w_mul ? {1'b0, r_mcand} : ~{1'b0, r_mcand};
  assign w_sum   = w_add_a + w_add_b + {{XLEN{1'b0}}, w_cin};

  // shift-add multiply step or restoring divide step
  always_comb begin
    w_acc_nxt = r_acc;
    if (w_mul)
      w_acc_nxt = r_acc[0] ? {w_sum, r_acc[XLEN-1:1]}
                           : {1'b0, w_hi, r_acc[XLEN-1:1]};
    else if (w_sum[XLEN])
      w_acc_nxt = {r_acc[2*XLEN-2:0], 1'b0};
    else
      w_acc_nxt = {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  end

  assign w_prod = r_neg ? ('0 - w_acc_nxt) : w_acc_nxt;
  assign w_quo  = w_acc_nxt[XLEN-1:0];
  assign w_remv = w_acc_nxt[2*XLEN-1:XLEN];

  // sign fix-up and half select of the finished iterative op
  always_comb begin
    w_fin = '0;
    if (w_mul)
      w_fin = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    else if (r_rem)
      w_fin = r_neg_rem ? ('0 - w_remv) : w_remv;
    else
      w_fin = r_neg ? ('0 - w_quo) : w_quo;
  end

  // FSM and iterative datapath state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= 1'b0;
      r_rem     <= 1'b0;
      r_eq_p    <= 1'b0;
      r_slt_p   <= 1'b0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else if (w_idle) begin
      if (w_acc && w_iter) begin
        r_state   <= i_opsel[2] ? S_DIV : S_MUL;
        r_cnt     <= '0;
        r_acc     <= {{XLEN{1'b0}}, i_opsel[2] ? w_mag1 : w_mag2};
        r_mcand   <= i_opsel[2] ? w_mag2 : w_mag1;
        r_neg     <= w_neg1 ^ w_neg2;
        r_neg_rem <= w_neg1;
        r_hi      <= (i_opsel[1:0] != 2'b00);
        r_rem     <= i_opsel[1];
        r_eq_p    <= w_core_eq;
        r_slt_p   <= w_core_slt;
      end
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + SHAMT_W'(1);
      if (w_last)
        r_state <= S_IDLE;
    end
  end

  // result register with valid/ready hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_eq     <= 1'b0;
      r_slt    <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_idle) begin
      if (w_acc && !w_iter) begin
        r_valid  <= 1'b1;
        r_result <= i_mext ? w_spec_res : w_core_res;
        r_eq     <= w_core_eq;
        r_slt    <= w_core_slt;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
    end else if (w_last) begin
      r_valid  <= 1'b1;
      r_result <= w_fin;
      r_eq     <= r_eq_p;
      r_slt    <= r_slt_p;
    end
  end

  assign o_valid  = r_valid;
  assign o_result = r_result;
  assign o_eq     = r_eq;
  assign o_slt    = r_slt;
  assign o_busy   = !w_idle;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at XLEN=32 and XLEN=8.
// Expected values are hand-computed constants.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v = 1'b0;
  logic        mext = 1'b0;
  logic [2:0]  opsel = 3'b000;
  logic        sub = 1'b0;
  logic        uns = 1'b0;
  logic        arith = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        flush = 1'b0;
  logic        rdy = 1'b1;
  logic        o_ready, o_valid, o_eq, o_slt, o_busy;
  logic [31:0] o_result;

  logic        v8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        o_ready8, o_valid8, o_eq8, o_slt8, o_busy8;
  logic [7:0]  o_result8;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v), .o_ready(o_ready),
    .i_mext(mext), .i_opsel(opsel), .i_sub(sub), .i_unsigned(uns),
    .i_arith(arith), .i_op1(op1), .i_op2(op2), .i_flush(flush),
    .o_valid(o_valid), .i_ready(rdy), .o_result(o_result),
    .o_eq(o_eq), .o_slt(o_slt), .o_busy(o_busy)
  );

  alu_seq #(.XLEN(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(o_ready8),
    .i_mext(mext), .i_opsel(opsel), .i_sub(sub), .i_unsigned(uns),
    .i_arith(arith), .i_op1(a8), .i_op2(b8), .i_flush(flush),
    .o_valid(o_valid8), .i_ready(rdy), .o_result(o_result8),
    .o_eq(o_eq8), .o_slt(o_slt8), .o_busy(o_busy8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic m, input logic [2:0] f,
                       input logic s, input logic u, input logic ar,
                       input logic [31:0] a, input logic [31:0] b);
    v = 1'b1; mext = m; opsel = f; sub = s; uns = u; arith = ar;
    op1 = a; op2 = b;
  endtask

  task automatic base(input string tag, input logic [2:0] f,
                      input logic s, input logic u, input logic ar,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input logic eqx,
                      input logic sltx);
    issue(1'b0, f, s, u, ar, a, b);
    #1;
    chk({tag, "_rdy"}, o_ready, 1);
    tick();
    chk({tag, "_vld"}, o_valid, 1);
    chk(tag, o_result, exp);
    chk({tag, "_eq"}, o_eq, eqx);
    chk({tag, "_slt"}, o_slt, sltx);
  endtask

  task automatic mop(input string tag, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    int n;
    issue(1'b1, f, 1'b0, 1'b0, 1'b0, a, b);
    #1;
    chk({tag, "_rdy"}, o_ready, 1);
    tick();
    v = 1'b0;
    n = 1;
    while (!o_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk(tag, o_result, exp);
  endtask

  initial begin
    int bad;
    int n;

    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_result", o_result, 0);
    chk("rst_eq", o_eq, 0);
    chk("rst_slt", o_slt, 0);
    chk("rst_busy", o_busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", o_ready, 1);

    base("add", OP_ADD, 0, 0, 0, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 1);
    base("sra", OP_SR, 0, 0, 1, 32'h80000000, 32'h4, 32'hF8000000, 0, 1);
    base("srl", OP_SR, 0, 0, 0, 32'h80000000, 32'h4, 32'h08000000, 0, 1);
    base("sltu", OP_SLTU, 0, 1, 0, 32'h1, 32'hFFFFFFFF, 32'h1, 0, 1);
    base("slt", OP_SLT, 0, 0, 0, 32'h1, 32'hFFFFFFFF, 32'h0, 0, 0);
    base("sub", OP_ADD, 1, 0, 0, 32'h5, 32'h7, 32'hFFFFFFFE, 0, 1);
    base("sll", OP_SLL, 0, 0, 0, 32'h1, 32'd31, 32'h80000000, 0, 1);
    base("xor", OP_XOR, 0, 0, 0, 32'hA5A5A5A5, 32'hFFFF0000,
         32'h5A5AA5A5, 0, 1);
    base("or", OP_OR, 0, 0, 0, 32'h0F0F0000, 32'h0000F0F0,
         32'h0F0FF0F0, 0, 0);
    base("and", OP_AND, 0, 0, 0, 32'h12345678, 32'h12345678,
         32'h12345678, 1, 0);
    v = 1'b0;
    tick();
    chk("drain_vld", o_valid, 0);

    issue(1'b1, F3_MULH, 0, 0, 0, 32'hFFFFFFFE, 32'h3);
    #1;
    chk("mulh_rdy", o_ready, 1);
    tick();
    v = 1'b0;
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (o_ready || o_valid || !o_busy) bad++;
      tick();
    end
    chk("mulh_wait", bad, 0);
    chk("mulh_vld", o_valid, 1);
    chk("mulh_busy", o_busy, 0);
    chk("mulh", o_result, 32'hFFFFFFFF);

    mop("mul", F3_MUL, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, 33);
    mop("mulhu", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    mop("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFF, 33);
    mop("div0", F3_DIV, 32'h7, 32'h0, 32'hFFFFFFFF, 1);
    mop("rem0", F3_REM, 32'h7, 32'h0, 32'h7, 1);
    mop("divovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    mop("removf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    mop("rem", F3_REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
    mop("div", F3_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
    mop("divu", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);
    mop("remu", F3_REMU, 32'd100, 32'd7, 32'd2, 33);

    tick();
    rdy = 1'b0;
    issue(1'b0, OP_ADD, 0, 0, 0, 32'd3, 32'd4);
    #1;
    chk("bp_rdy", o_ready, 1);
    tick();
    issue(1'b0, OP_AND, 0, 0, 0, 32'hF0, 32'h3C);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!o_valid || o_result != 32'd7 || o_eq || !o_slt || o_ready)
        bad++;
      tick();
    end
    chk("bp_hold", bad, 0);
    rdy = 1'b1;
    #1;
    chk("bp_release_rdy", o_ready, 1);
    tick();
    chk("bp_new_vld", o_valid, 1);
    chk("bp_new", o_result, 32'h30);
    chk("bp_new_slt", o_slt, 0);
    v = 1'b0;
    tick();

    issue(1'b1, F3_DIVU, 0, 0, 0, 32'd100, 32'd7);
    #1;
    tick();
    v = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    issue(1'b0, OP_ADD, 0, 0, 0, 32'd1, 32'd1);
    #1;
    chk("fl_rdy", o_ready, 0);
    tick();
    flush = 1'b0;
    v = 1'b0;
    #1;
    chk("fl_busy", o_busy, 0);
    chk("fl_vld", o_valid, 0);
    chk("fl_rdy_after", o_ready, 1);
    issue(1'b0, OP_ADD, 0, 0, 0, 32'd2, 32'd3);
    #1;
    tick();
    v = 1'b0;
    chk("fl_add", o_result, 32'd5);
    chk("fl_add_vld", o_valid, 1);
    tick();

    issue(1'b0, OP_ADD, 0, 0, 0, 32'd1, 32'd1);
    #1;
    tick();
    v = 1'b0;
    rdy = 1'b0;
    chk("flp_vld_pre", o_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rdy = 1'b1;
    chk("flp_vld", o_valid, 0);

    issue(1'b1, F3_DIVU, 0, 0, 0, 32'd100, 32'd7);
    #1;
    tick();
    v = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk("ar_busy", o_busy, 0);
    chk("ar_vld", o_valid, 0);
    chk("ar_res", o_result, 0);
    chk("ar_eq", o_eq, 0);
    rst_n = 1'b1;
    tick();
    chk("ar_rdy", o_ready, 1);
    base("ar_add", OP_ADD, 0, 0, 0, 32'd6, 32'd7, 32'hD, 0, 1);
    v = 1'b0;
    tick();

    mext = 1'b1;
    opsel = F3_MULHU;
    a8 = 8'hFF;
    b8 = 8'hFF;
    v8 = 1'b1;
    #1;
    chk("x8_rdy", o_ready8, 1);
    tick();
    v8 = 1'b0;
    n = 1;
    while (!o_valid8 && n < 40) begin
      tick();
      n++;
    end
    chk("x8_mulhu_lat", n, 9);
    chk("x8_mulhu", o_result8, 8'hFE);

    opsel = F3_DIV;
    a8 = 8'h80;
    b8 = 8'hFF;
    v8 = 1'b1;
    #1;
    tick();
    v8 = 1'b0;
    chk("x8_divovf_vld", o_valid8, 1);
    chk("x8_divovf", o_result8, 8'h80);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle combinational ALU: executes RV32I base ALU operations with one registered cycle of latency and adds RV32M multiply/divide/remainder as iterative multi-cycle operations. Sits between decode/operand-select and writeback. Uses valid/ready on both sides so the core can stall while a long operation is in flight.

## Interface

Parameters:
- `XLEN`, default 32: operand and result width. Legal values are powers of two, 8 or greater.
- `SHAMT_W`, localparam `$clog2(XLEN)`: width of the shift amount taken from `i_op2[SHAMT_W-1:0]`.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_valid`, in, 1: request valid.
- `o_ready`, out, 1: block accepts a request this cycle.
- `i_mext`, in, 1: when 1, `i_opsel` is an M-extension funct3; when 0, it is a base opcode.
- `i_opsel`, in, 3: base opcode, encoded as in the base ALU (000 add/sub, 001 sll, 01x slt, 100 xor, 101 srl/sra, 110 or, 111 and), or the M funct3.
- `i_sub`, in, 1: selects subtract for base 000.
- `i_unsigned`, in, 1: selects unsigned slt and `o_slt`.
- `i_arith`, in, 1: selects arithmetic right shift.
- `i_op1`, in, XLEN: first operand.
- `i_op2`, in, XLEN: second operand.
- `i_flush`, in, 1: synchronous kill of any in-flight operation and any pending result.
- `o_valid`, out, 1: result valid.
- `i_ready`, in, 1: downstream accepts the result.
- `o_result`, out, XLEN: result.
- `o_eq`, out, 1: `i_op1 == i_op2` for the accepted request, registered alongside the result.
- `o_slt`, out, 1: less-than for the accepted request (signed, or unsigned per `i_unsigned`), registered alongside the result.
- `o_busy`, out, 1: FSM is in MUL or DIV.

## Operation

- **Accept:** a request is accepted when `i_valid && o_ready`. Operands and controls are captured on acceptance.
- **Ready rule:** `o_ready = (state==IDLE) && (!o_valid || i_ready)`.
- **FSM states and transitions:**
  - IDLE to IDLE on accept of a base op, or of a special-case DIV/REM (see below). The result is loaded and `o_valid` is set.
  - IDLE to MUL on accept of funct3 000–011.
  - IDLE to DIV on accept of funct3 100–111.
  - MUL or DIV to IDLE after XLEN iteration cycles. The result is loaded and `o_valid` is set.
- **M funct3 codes:** 000 MUL (low XLEN bits), 001 MULH (signed×signed), 010 MULHSU (signed×unsigned), 011 MULHU (unsigned×unsigned), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- **Multiply:**
  - Take magnitudes of operands treated as signed.
  - Run XLEN iterations of radix-2 shift-add into a 2·XLEN accumulator.
  - Negate the product if exactly one signed operand is negative.
- **Divide:**
  - Restoring divide on magnitudes, one quotient bit per cycle, XLEN cycles.
  - Quotient sign is the XOR of operand signs; remainder takes the sign of the dividend.
- **Special cases,** resolved in IDLE with a 1-cycle result:
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return `op1`.
  - Signed overflow (`op1` = most negative, `op2` = −1): DIV returns `op1`; REM returns 0.
- **Base-op width rules:** all arithmetic is modulo 2^XLEN, with carry discarded. Base slt writes 1 or 0 zero-extended to XLEN.
- **Output hold:** `o_result`, `o_eq` and `o_slt` stay stable while `o_valid && !i_ready`.
- **Flush:**
  - `i_flush` forces IDLE and clears `o_valid` on the next edge.
  - Flush has priority over accept and over completion in the same cycle.
  - `o_ready` is 0 during a flush cycle.
- **Async reset:** reset mid-operation aborts to IDLE immediately.

## Timing

- **Reset values:** `o_valid`=0, `o_result`=0, `o_eq`=0, `o_slt`=0, `o_busy`=0, state=IDLE. `o_ready`=1 after reset deassertion.
- **Base op and special-case div latency:** `o_valid` rises on the edge after acceptance, i.e. 1 cycle.
- **MUL/DIV latency:** `o_valid` rises XLEN+1 edges after acceptance. `o_ready` is 0 for the whole of that period.
- **Back-to-back base ops:** with `i_ready` held at 1, one result per cycle.
- **Simultaneous consume and accept:** `o_valid && i_ready` in the same cycle as a new accept replaces the result without a bubble.
- **Stalled completion:** an iterative op finishing while `o_valid && !i_ready` cannot happen, because `o_ready` gated the accept.

## Structure

- **Package `alu_pkg`:**
  - base opsel constants;
  - M funct3 constants;
  - FSM state enum (IDLE, MUL, DIV).
- **Sub-module `alu_core`:** purely combinational, parametrised by XLEN. It computes the base op result, eq and slt. `alu_seq` instantiates it once and registers its outputs.
- **Multiply/divide datapath:** lives in `alu_seq` and shares one XLEN+1-bit adder between MUL and DIV.

## Test plan

- Base ops with XLEN=32, back-to-back and `i_ready`=1:
  - add `0xFFFFFFFF`+1 gives 0, 1 cycle after accept;
  - sra `0x80000000`>>4 gives `0xF8000000`;
  - sltu `1`<`0xFFFFFFFF` gives 1.
- MULH −2 × 3 gives `0xFFFFFFFF`; MUL gives `0xFFFFFFFA`. `o_valid` at cycle 33. `o_ready`=0 on cycles 1–32.
- Special cases:
  - DIV 7/0 gives `0xFFFFFFFF`, 1 cycle;
  - REM 7/0 gives 7;
  - DIV `0x80000000`/−1 gives `0x80000000`;
  - REM −7/2 gives −1 (`0xFFFFFFFF`), after 33 cycles.
- Backpressure: hold `i_ready`=0 for 5 cycles after a result. `o_result`, `o_eq` and `o_slt` stay stable and `o_ready`=0. Releasing `i_ready` with a new `i_valid` accepts in the same cycle.
- Flush and reset:
  - assert `i_flush` at cycle 10 of a DIVU: IDLE next cycle, no `o_valid`, a new add accepted the following cycle;
  - repeat with `i_rst_n` pulsed low instead: outputs go to 0 immediately.
- Parametrisation: XLEN=8, MULHU `0xFF`×`0xFF` gives `0xFE`, with `o_valid` 9 cycles after accept.
